ex_mem_ctrl_pipe: RTL and testbench

Registered EX/MEM pipeline stage for control and data, placed between the execute stage and the memory stage. It applies flush, NPU-stall and downstream-hold policy inside the register, with a parametrised control width and a configurable set of control bits that survive an NPU stall. When `DEFER_FLUSH=1`, a flush that collides with a cache hit is kept pending and applied later instead of being dropped. A saturating counter records how many bubbles the stage has inserted, for performance monitoring.

---
 rtl/ex_mem_ctrl_pipe_if.sv | 30 +++
 rtl/ex_mem_ctrl_pipe.sv | 85 ++++++++
 tb/tb_ex_mem_ctrl_pipe.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_ctrl_pipe_if.sv
// rtl/ex_mem_ctrl_pipe_if.sv - EX/MEM stage bus: EX-side inputs, MEM-side outputs, policy controls
interface ex_mem_ctrl_pipe_if #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_data;
  logic              ex_valid;
  logic              flush;
  logic              hit;
  logic              npu_stall;
  logic              mem_hold;
  logic              cnt_clr;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;
  logic              flush_pending;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output ex_ctrl, ex_data, ex_valid, flush, hit, npu_stall, mem_hold, cnt_clr,
    input  mem_ctrl, mem_data, mem_valid, flush_pending, bubble_cnt
  );

  modport slave (
    input  ex_ctrl, ex_data, ex_valid, flush, hit, npu_stall, mem_hold, cnt_clr,
    output mem_ctrl, mem_data, mem_valid, flush_pending, bubble_cnt
  );
endinterface

// File: rtl/ex_mem_ctrl_pipe.sv
// rtl/ex_mem_ctrl_pipe.sv - EX/MEM pipeline register with flush/NPU-stall/hold policy and bubble counter
module ex_mem_ctrl_pipe #(
  parameter int                CTRL_W      = 5,
  parameter int                DATA_W      = 32,
  parameter logic [CTRL_W-1:0] KEEP_MASK   = {1'b1, {(CTRL_W-1){1'b0}}},
  parameter bit                DEFER_FLUSH = 1'b1,
  parameter int                CNT_W       = 8
) (
  input logic              clk,
  input logic              reset,
  ex_mem_ctrl_pipe_if.slave bus
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q;

  logic eff_flush;
  logic defer_hit;
  logic stall;
  logic bubble;

  // A pending flush behaves like a live one, but a cache hit masks both.
  assign eff_flush = (bus.flush | (state == PEND)) & ~bus.hit;
  assign defer_hit = DEFER_FLUSH & bus.flush & bus.hit;
  assign stall     = bus.npu_stall & ~bus.hit;
  // Rule 2 needs hit=1, so it can never coincide with a stall bubble.
  assign bubble    = ~bus.mem_hold & (eff_flush | stall);

  // Pipeline register and RUN/PEND state; pending state is the flush_pending output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      ctrl_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (bus.mem_hold) begin
      if (DEFER_FLUSH && bus.flush) begin
        state <= PEND;
      end
    end else if (eff_flush) begin
      state   <= RUN;
      ctrl_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (defer_hit) begin
      state   <= PEND;
      ctrl_q  <= bus.ex_ctrl;
      data_q  <= bus.ex_data;
      valid_q <= bus.ex_valid;
    end else if (stall) begin
      ctrl_q  <= bus.ex_ctrl & KEEP_MASK;
      data_q  <= bus.ex_data;
      valid_q <= bus.ex_valid;
    end else begin
      ctrl_q  <= bus.ex_ctrl;
      data_q  <= bus.ex_data;
      valid_q <= bus.ex_valid;
    end
  end

  // Saturating bubble counter; clear has priority over a same-cycle bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (bubble && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.mem_ctrl      = ctrl_q;
  assign bus.mem_data      = data_q;
  assign bus.mem_valid     = valid_q;
  assign bus.flush_pending = (state == PEND);
  assign bus.bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_ex_mem_ctrl_pipe.sv
// tb/tb_ex_mem_ctrl_pipe.sv - scoreboard bench for ex_mem_ctrl_pipe in three parameter sets
module tb_ex_mem_ctrl_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0]  ex_ctrl;
  logic [31:0] ex_data;
  logic        ex_valid, flush, hit, npu_stall, mem_hold, cnt_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // a: defaults, b: DEFER_FLUSH=0, c: CNT_W=3
  ex_mem_ctrl_pipe_if #(.CTRL_W(5), .DATA_W(32), .CNT_W(8)) if_a ();
  ex_mem_ctrl_pipe_if #(.CTRL_W(5), .DATA_W(32), .CNT_W(8)) if_b ();
  ex_mem_ctrl_pipe_if #(.CTRL_W(5), .DATA_W(32), .CNT_W(3)) if_c ();

  ex_mem_ctrl_pipe #(.CTRL_W(5), .DATA_W(32), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  ex_mem_ctrl_pipe #(.CTRL_W(5), .DATA_W(32), .DEFER_FLUSH(1'b0), .CNT_W(8)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  ex_mem_ctrl_pipe #(.CTRL_W(5), .DATA_W(32), .CNT_W(3)) dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  assign if_a.ex_ctrl = ex_ctrl;  assign if_a.ex_data = ex_data;  assign if_a.ex_valid = ex_valid;
  assign if_a.flush = flush;  assign if_a.hit = hit;  assign if_a.npu_stall = npu_stall;
  assign if_a.mem_hold = mem_hold;  assign if_a.cnt_clr = cnt_clr;
  assign if_b.ex_ctrl = ex_ctrl;  assign if_b.ex_data = ex_data;  assign if_b.ex_valid = ex_valid;
  assign if_b.flush = flush;  assign if_b.hit = hit;  assign if_b.npu_stall = npu_stall;
  assign if_b.mem_hold = mem_hold;  assign if_b.cnt_clr = cnt_clr;
  assign if_c.ex_ctrl = ex_ctrl;  assign if_c.ex_data = ex_data;  assign if_c.ex_valid = ex_valid;
  assign if_c.flush = flush;  assign if_c.hit = hit;  assign if_c.npu_stall = npu_stall;
  assign if_c.mem_hold = mem_hold;  assign if_c.cnt_clr = cnt_clr;

  logic [4:0]  o_ctrl  [3];
  logic [31:0] o_data  [3];
  logic        o_valid [3];
  logic        o_pend  [3];
  logic [7:0]  o_cnt   [3];

  assign o_ctrl[0] = if_a.mem_ctrl;  assign o_data[0] = if_a.mem_data;  assign o_valid[0] = if_a.mem_valid;
  assign o_pend[0] = if_a.flush_pending;  assign o_cnt[0] = if_a.bubble_cnt;
  assign o_ctrl[1] = if_b.mem_ctrl;  assign o_data[1] = if_b.mem_data;  assign o_valid[1] = if_b.mem_valid;
  assign o_pend[1] = if_b.flush_pending;  assign o_cnt[1] = if_b.bubble_cnt;
  assign o_ctrl[2] = if_c.mem_ctrl;  assign o_data[2] = if_c.mem_data;  assign o_valid[2] = if_c.mem_valid;
  assign o_pend[2] = if_c.flush_pending;  assign o_cnt[2] = {5'b0, if_c.bubble_cnt};

  // Reference state per instance, written from the stage rules.
  logic [4:0]  m_ctrl  [3];
  logic [31:0] m_data  [3];
  logic        m_valid [3];
  logic        m_pend  [3];
  int          m_cnt   [3];
  bit          dfr     [3] = '{1'b1, 1'b0, 1'b1};
  int          cmax    [3] = '{255, 255, 7};

  typedef struct {
    int          dut;
    logic [4:0]  ctrl;
    logic [31:0] data;
    logic        valid;
    logic        pend;
    logic [7:0]  cnt;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 3; i++) begin
      m_ctrl[i] = '0; m_data[i] = '0; m_valid[i] = 1'b0; m_pend[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  // Compute expectations for the coming edge, push them, clock, then pop and compare.
  task automatic step();
    exp_t e;
    logic eff, bub;
    for (int i = 0; i < 3; i++) begin
      bub = 1'b0;
      if (reset) begin
        m_ctrl[i] = '0; m_data[i] = '0; m_valid[i] = 1'b0; m_pend[i] = 1'b0; m_cnt[i] = 0;
      end else begin
        eff = (flush | m_pend[i]) & ~hit;
        if (mem_hold) begin
          if (flush && dfr[i]) m_pend[i] = 1'b1;
        end else if (eff) begin
          m_ctrl[i] = '0; m_data[i] = '0; m_valid[i] = 1'b0; m_pend[i] = 1'b0; bub = 1'b1;
        end else if (flush && hit && dfr[i]) begin
          m_ctrl[i] = ex_ctrl; m_data[i] = ex_data; m_valid[i] = ex_valid; m_pend[i] = 1'b1;
        end else if (npu_stall && !hit) begin
          m_ctrl[i] = ex_ctrl & 5'h10; m_data[i] = ex_data; m_valid[i] = ex_valid; bub = 1'b1;
        end else begin
          m_ctrl[i] = ex_ctrl; m_data[i] = ex_data; m_valid[i] = ex_valid;
        end
        if (cnt_clr) m_cnt[i] = 0;
        else if (bub && m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
      end
      e.dut = i; e.ctrl = m_ctrl[i]; e.data = m_data[i]; e.valid = m_valid[i];
      e.pend = m_pend[i]; e.cnt = 8'(m_cnt[i]);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("sb%0d.ctrl", e.dut),  64'(o_ctrl[e.dut]),  64'(e.ctrl));
      chk($sformatf("sb%0d.data", e.dut),  64'(o_data[e.dut]),  64'(e.data));
      chk($sformatf("sb%0d.valid", e.dut), 64'(o_valid[e.dut]), 64'(e.valid));
      chk($sformatf("sb%0d.pend", e.dut),  64'(o_pend[e.dut]),  64'(e.pend));
      chk($sformatf("sb%0d.cnt", e.dut),   64'(o_cnt[e.dut]),   64'(e.cnt));
    end
  endtask

  initial begin
    model_zero();
    reset = 1'b1;
    ex_ctrl = 5'h1F; ex_data = 32'h0; ex_valid = 1'b1;
    flush = 0; hit = 0; npu_stall = 0; mem_hold = 0; cnt_clr = 0;
    #1;
    chk("reset_async_ctrl", 64'(if_a.mem_ctrl), 64'h0);

    // Reset state with live inputs
    repeat (3) step();
    chk("reset_valid", 64'(if_a.mem_valid), 64'h0);
    reset = 1'b0;
    ex_data = 32'hDEADBEEF;
    step();
    chk("load_ctrl", 64'(if_a.mem_ctrl), 64'h1F);
    chk("load_data", 64'(if_a.mem_data), 64'hDEADBEEF);
    chk("load_valid", 64'(if_a.mem_valid), 64'h1);

    // NPU stall without and with hit
    npu_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("npu_mask", 64'(if_a.mem_ctrl), 64'h10);
      chk("npu_cnt", 64'(if_a.bubble_cnt), 64'(k + 1));
    end
    hit = 1'b1;
    repeat (4) begin
      step();
      chk("npu_hit_ctrl", 64'(if_a.mem_ctrl), 64'h1F);
      chk("npu_hit_cnt", 64'(if_a.bubble_cnt), 64'd4);
    end

    // Deferred flush (counter cleared on the first cycle)
    npu_stall = 1'b0;
    flush = 1'b1; cnt_clr = 1'b1; ex_ctrl = 5'h03; ex_data = 32'h1;
    step();
    chk("defer_pend_a", 64'(if_a.flush_pending), 64'h1);
    chk("defer_pend_b", 64'(if_b.flush_pending), 64'h0);
    flush = 1'b0; cnt_clr = 1'b0;
    ex_ctrl = 5'h04; ex_data = 32'h2; step();
    ex_ctrl = 5'h05; ex_data = 32'h3; step();
    chk("defer_load", 64'(if_a.mem_ctrl), 64'h05);
    chk("defer_still_pend", 64'(if_a.flush_pending), 64'h1);
    hit = 1'b0; ex_ctrl = 5'h06; ex_data = 32'h4;
    step();
    chk("defer_fire_ctrl", 64'(if_a.mem_ctrl), 64'h0);
    chk("defer_fire_valid", 64'(if_a.mem_valid), 64'h0);
    chk("defer_fire_pend", 64'(if_a.flush_pending), 64'h0);
    chk("defer_fire_cnt", 64'(if_a.bubble_cnt), 64'd1);
    chk("legacy_no_flush", 64'(if_b.mem_ctrl), 64'h06);

    // Hold with a flush in the middle cycle
    ex_ctrl = 5'h07; ex_data = 32'h77; step();
    mem_hold = 1'b1; ex_ctrl = 5'h09; ex_data = 32'h99;
    step();
    flush = 1'b1; step();
    chk("hold_pend", 64'(if_a.flush_pending), 64'h1);
    flush = 1'b0; step();
    chk("hold_frozen", 64'(if_a.mem_ctrl), 64'h07);
    chk("hold_frozen_data", 64'(if_a.mem_data), 64'h77);
    mem_hold = 1'b0; ex_ctrl = 5'h08;
    step();
    chk("hold_release_flush", 64'(if_a.mem_ctrl), 64'h0);
    chk("hold_release_cnt", 64'(if_a.bubble_cnt), 64'd2);
    chk("hold_legacy_lost", 64'(if_b.mem_ctrl), 64'h08);

    // Saturation and clear on the 3-bit counter
    npu_stall = 1'b1; ex_ctrl = 5'h1F;
    repeat (10) step();
    chk("sat_cnt", 64'(if_c.bubble_cnt), 64'd7);
    cnt_clr = 1'b1; step();
    chk("clr_wins", 64'(if_c.bubble_cnt), 64'd0);
    cnt_clr = 1'b0; npu_stall = 1'b0;

    // Reset while pending
    flush = 1'b1; hit = 1'b1; ex_ctrl = 5'h0C; step();
    chk("pre_reset_pend", 64'(if_a.flush_pending), 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_pend", 64'(if_a.flush_pending), 64'h0);
    chk("reset_mid_ctrl", 64'(if_a.mem_ctrl), 64'h0);
    model_zero();
    #1 reset = 1'b0;
    flush = 1'b0; hit = 1'b0; ex_ctrl = 5'h0B;
    step();
    chk("post_reset_pass", 64'(if_a.mem_ctrl), 64'h0B);

    // Random traffic through the scoreboard
    for (int k = 0; k < 40; k++) begin
      ex_ctrl = 5'($urandom); ex_data = $urandom; ex_valid = 1'($urandom);
      flush = ($urandom_range(0, 3) == 0); hit = 1'($urandom);
      npu_stall = 1'($urandom); mem_hold = ($urandom_range(0, 3) == 0);
      cnt_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
